oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_if.sv | 26 ++
 rtl/oam_dma.sv | 132 +++++++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// Bundle of CPU-side and memory-side signals for the OAM DMA engine.
// The slave modport is the DMA block's view; the master modport is the
// surrounding system (CPU + memory) that drives the requests and read data.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wen;
    logic        rdy;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        done;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wen, bus_rdata,
        output rdy, dma_active, bus_addr, bus_ren, bus_wen, bus_wdata, done
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wen, bus_rdata,
        input  rdy, dma_active, bus_addr, bus_ren, bus_wen, bus_wdata, done
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write of a page number to $4014 halts the CPU and
// copies 256 bytes from {page,00..FF} to the OAM data port at $2004.
// Reads and writes alternate on the bus; a one-cycle alignment slot is
// inserted when the transfer would otherwise start on an odd cycle.
module oam_dma (
    input  logic       clk,
    input  logic       rst,
    oam_dma_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_DATA    = 16'h2004;

    state_t      r_state;
    logic        r_p;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic        r_rdy;
    logic        r_active;
    logic [15:0] r_addr;
    logic        r_ren;
    logic        r_wen;
    logic        r_done;

    logic        w_trigger;
    logic [7:0]  w_idx_next;

    assign w_trigger  = bus.cpu_wen && (bus.cpu_addr == OAM_DMA_REG);
    assign w_idx_next = r_idx + 8'd1;

    // Cycle parity: the read slot must land on a cycle where p is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_p <= 1'b0;
        else     r_p <= ~r_p;
    end

    // Transfer sequencer with registered bus/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
            r_addr   <= 16'h0000;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page  <= bus.cpu_wdata;
                        r_idx   <= 8'h00;
                        r_rdy   <= 1'b0;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    // p flips on this edge, so p=1 now means the next cycle is even.
                    if (r_p) begin
                        r_state  <= READ;
                        r_active <= 1'b1;
                        r_ren    <= 1'b1;
                        r_addr   <= {r_page, r_idx};
                    end else begin
                        r_state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_state  <= READ;
                    r_active <= 1'b1;
                    r_ren    <= 1'b1;
                    r_addr   <= {r_page, r_idx};
                end
                READ: begin
                    r_state <= WRITE;
                    r_ren   <= 1'b0;
                    r_wen   <= 1'b1;
                    r_addr  <= OAM_DATA;
                end
                WRITE: begin
                    r_idx <= w_idx_next;
                    r_wen <= 1'b0;
                    if (r_idx == 8'hFF) begin
                        // Index is 8 bits only, so the page never increments.
                        r_state  <= DONE;
                        r_active <= 1'b0;
                        r_addr   <= 16'h0000;
                        r_rdy    <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_state  <= READ;
                        r_ren    <= 1'b1;
                        r_addr   <= {r_page, w_idx_next};
                    end
                end
                DONE: begin
                    // Any $4014 write seen here is dropped on purpose.
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_rdy    <= 1'b1;
                    r_active <= 1'b0;
                    r_addr   <= 16'h0000;
                    r_ren    <= 1'b0;
                    r_wen    <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy        = r_rdy;
    assign bus.dma_active = r_active;
    assign bus.bus_addr   = r_addr;
    assign bus.bus_ren    = r_ren;
    assign bus.bus_wen    = r_wen;
    assign bus.done       = r_done;
    // Memory returns data in the cycle after the read, i.e. during WRITE.
    assign bus.bus_wdata  = r_wen ? bus.bus_rdata : 8'h00;
endmodule
